// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : RISC-V immediate generator behind a valid/ready skid buffer,
//               with a saturating counter of accepted illegal opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN      = 64,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [31:0]          i_instr,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [XLEN-1:0]      o_imm,
  output logic [2:0]           o_fmt,
  output logic                 o_illegal,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  input  logic                 i_err_clr
);

  localparam logic [2:0] C_FMT_NONE = 3'd0;
  localparam logic [2:0] C_FMT_I    = 3'd1;
  localparam logic [2:0] C_FMT_S    = 3'd2;
  localparam logic [2:0] C_FMT_B    = 3'd3;
  localparam logic [2:0] C_FMT_U    = 3'd4;
  localparam logic [2:0] C_FMT_J    = 3'd5;

  localparam logic [6:0] C_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;

  logic [2:0]      w_fmt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  logic            w_accept;
  logic            w_drain;
  logic            w_err_inc;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_imm;
  logic [2:0]      r_out_fmt;
  logic            r_out_illegal;

  logic            r_skid_valid;
  logic [XLEN-1:0] r_skid_imm;
  logic [2:0]      r_skid_fmt;
  logic            r_skid_illegal;

  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Every format is first assembled as a 32-bit signed value, then widened.
  always_comb begin
    w_fmt   = C_FMT_NONE;
    w_imm32 = '0;
    case (i_instr[6:0])
      C_OP_OPIMM, C_OP_LOAD, C_OP_JALR: begin
        w_fmt   = C_FMT_I;
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      C_OP_STORE: begin
        w_fmt   = C_FMT_S;
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      C_OP_BRANCH: begin
        w_fmt   = C_FMT_B;
        w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                   i_instr[30:25], i_instr[11:8], 1'b0};
      end
      C_OP_LUI, C_OP_AUIPC: begin
        w_fmt   = C_FMT_U;
        w_imm32 = {i_instr[31:12], 12'b0};
      end
      C_OP_JAL: begin
        w_fmt   = C_FMT_J;
        w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                   i_instr[20], i_instr[30:21], 1'b0};
      end
      default: begin
        w_fmt   = C_FMT_NONE;
        w_imm32 = '0;
      end
    endcase
  end

  assign w_illegal = (w_fmt == C_FMT_NONE);

  if (XLEN == 32) begin : g_xlen32
    assign w_imm = w_imm32;
  end else begin : g_xlen64
    assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
  end

  // Ready is forced low while reset is held so nothing is accepted then.
  assign o_ready  = i_rst_n & ~r_skid_valid;
  assign w_accept = i_valid & o_ready;
  assign w_drain  = r_out_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_imm      <= '0;
      r_out_fmt      <= C_FMT_NONE;
      r_out_illegal  <= 1'b0;
      r_skid_valid   <= 1'b0;
      r_skid_imm     <= '0;
      r_skid_fmt     <= C_FMT_NONE;
      r_skid_illegal <= 1'b0;
    end else if (r_skid_valid) begin
      // No accept is possible here; the skid entry advances on drain.
      if (w_drain) begin
        r_out_imm     <= r_skid_imm;
        r_out_fmt     <= r_skid_fmt;
        r_out_illegal <= r_skid_illegal;
        r_skid_valid  <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_out_valid || w_drain) begin
        r_out_valid   <= 1'b1;
        r_out_imm     <= w_imm;
        r_out_fmt     <= w_fmt;
        r_out_illegal <= w_illegal;
      end else begin
        r_skid_valid   <= 1'b1;
        r_skid_imm     <= w_imm;
        r_skid_fmt     <= w_fmt;
        r_skid_illegal <= w_illegal;
      end
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  assign w_err_inc = w_accept & w_illegal & ~(&r_err_cnt);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
    end else if (i_err_clr) begin
      r_err_cnt <= '0;
    end else if (w_err_inc) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign o_valid   = r_out_valid;
  assign o_imm     = r_out_imm;
  assign o_fmt     = r_out_fmt;
  assign o_illegal = r_out_illegal;
  assign o_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// Directed self-checking bench for imm_gen_pipe: a 64-bit instance, a 32-bit
// instance and a 2-bit error-counter instance share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [31:0] instr;
  logic        rdy;
  logic        err_clr;

  logic        ready64, valid64, illegal64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [7:0]  cnt64;

  logic        ready32, valid32, illegal32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [7:0]  cnt32;

  logic        ready_e2, valid_e2, illegal_e2;
  logic [63:0] imm_e2;
  logic [2:0]  fmt_e2;
  logic [1:0]  cnt_e2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  imm_gen_pipe #(.XLEN(64), .ERR_CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready64),
    .i_instr(instr), .o_valid(valid64), .i_ready(rdy), .o_imm(imm64),
    .o_fmt(fmt64), .o_illegal(illegal64), .o_err_cnt(cnt64), .i_err_clr(err_clr)
  );

  imm_gen_pipe #(.XLEN(32), .ERR_CNT_W(8)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready32),
    .i_instr(instr), .o_valid(valid32), .i_ready(rdy), .o_imm(imm32),
    .o_fmt(fmt32), .o_illegal(illegal32), .o_err_cnt(cnt32), .i_err_clr(err_clr)
  );

  imm_gen_pipe #(.XLEN(64), .ERR_CNT_W(2)) dut_e2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready_e2),
    .i_instr(instr), .o_valid(valid_e2), .i_ready(rdy), .o_imm(imm_e2),
    .o_fmt(fmt_e2), .o_illegal(illegal_e2), .o_err_cnt(cnt_e2), .i_err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; instr = 32'h0; rdy = 1'b0; err_clr = 1'b0;
    step(); step();
    total_cnt++;
    if (valid64 !== 1'b0 || ready64 !== 1'b0)
      $display("FAIL reset_handshake: o_valid=%b o_ready=%b, expected 0 0", valid64, ready64);
    else pass_cnt++;
    total_cnt++;
    if (imm64 !== 64'h0 || fmt64 !== 3'd0 || illegal64 !== 1'b0 || cnt64 !== 8'h0)
      $display("FAIL reset_outputs: imm=%h fmt=%0d ill=%b cnt=%0d, expected all 0",
               imm64, fmt64, illegal64, cnt64);
    else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (ready64 !== 1'b1)
      $display("FAIL reset_release_ready: o_ready=%b, expected 1", ready64);
    else pass_cnt++;
  endtask

  task automatic test_addi();
    rdy = 1'b1; valid = 1'b1; instr = 32'hFFF00093;
    step();
    valid = 1'b0;
    total_cnt++;
    if (valid64 !== 1'b1 || fmt64 !== 3'd1 || imm64 !== 64'hFFFFFFFFFFFFFFFF || illegal64 !== 1'b0)
      $display("FAIL addi_m1: v=%b fmt=%0d imm=%h ill=%b, expected 1 1 ffffffffffffffff 0",
               valid64, fmt64, imm64, illegal64);
    else pass_cnt++;
    step();
    total_cnt++;
    if (valid64 !== 1'b0)
      $display("FAIL addi_drain: o_valid=%b, expected 0", valid64);
    else pass_cnt++;
  endtask

  task automatic test_formats();
    logic [31:0] v_in [9];
    logic [2:0]  v_fmt [9];
    logic [63:0] v_i64 [9];
    logic [31:0] v_i32 [9];
    v_in[0] = 32'hFE000EE3; v_fmt[0] = 3'd3; v_i64[0] = 64'hFFFFFFFFFFFFFFFC; v_i32[0] = 32'hFFFFFFFC;
    v_in[1] = 32'h0080006F; v_fmt[1] = 3'd5; v_i64[1] = 64'h8;                v_i32[1] = 32'h8;
    v_in[2] = 32'h800002B7; v_fmt[2] = 3'd4; v_i64[2] = 64'hFFFFFFFF80000000; v_i32[2] = 32'h80000000;
    v_in[3] = 32'hFE512C23; v_fmt[3] = 3'd2; v_i64[3] = 64'hFFFFFFFFFFFFFFF8; v_i32[3] = 32'hFFFFFFF8;
    v_in[4] = 32'h7FF02003; v_fmt[4] = 3'd1; v_i64[4] = 64'h7FF;              v_i32[4] = 32'h7FF;
    v_in[5] = 32'h00008067; v_fmt[5] = 3'd1; v_i64[5] = 64'h0;                v_i32[5] = 32'h0;
    v_in[6] = 32'h12345017; v_fmt[6] = 3'd4; v_i64[6] = 64'h12345000;         v_i32[6] = 32'h12345000;
    v_in[7] = 32'h0000007F; v_fmt[7] = 3'd0; v_i64[7] = 64'h0;                v_i32[7] = 32'h0;
    v_in[8] = 32'hFFFFFFF3; v_fmt[8] = 3'd0; v_i64[8] = 64'h0;                v_i32[8] = 32'h0;
    rdy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      valid = 1'b1; instr = v_in[k];
      step();
      valid = 1'b0;
      total_cnt++;
      if (valid64 !== 1'b1 || fmt64 !== v_fmt[k] || imm64 !== v_i64[k] ||
          illegal64 !== (v_fmt[k] == 3'd0))
        $display("FAIL fmt64[%0d] instr=%h: v=%b fmt=%0d imm=%h ill=%b, expected 1 %0d %h %b",
                 k, v_in[k], valid64, fmt64, imm64, illegal64, v_fmt[k], v_i64[k], v_fmt[k] == 3'd0);
      else pass_cnt++;
      total_cnt++;
      if (valid32 !== 1'b1 || fmt32 !== v_fmt[k] || imm32 !== v_i32[k])
        $display("FAIL fmt32[%0d] instr=%h: v=%b fmt=%0d imm=%h, expected 1 %0d %h",
                 k, v_in[k], valid32, fmt32, imm32, v_fmt[k], v_i32[k]);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v_in [3];
    v_in[0] = 32'h00100093; v_in[1] = 32'h00200093; v_in[2] = 32'h00300093;
    rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1; instr = v_in[k];
      step();
      total_cnt++;
      if (valid64 !== 1'b1 || imm64 !== 64'(k + 1) || ready64 !== 1'b1)
        $display("FAIL b2b[%0d]: v=%b imm=%h rdy=%b, expected 1 %h 1",
                 k, valid64, imm64, ready64, 64'(k + 1));
      else pass_cnt++;
    end
    valid = 1'b0;
    step();
    total_cnt++;
    if (valid64 !== 1'b0)
      $display("FAIL b2b_empty: o_valid=%b, expected 0", valid64);
    else pass_cnt++;
  endtask

  task automatic test_skid();
    rdy = 1'b0;
    valid = 1'b1; instr = 32'h00500093;
    step();
    total_cnt++;
    if (valid64 !== 1'b1 || imm64 !== 64'h5 || ready64 !== 1'b1)
      $display("FAIL skid_first: v=%b imm=%h rdy=%b, expected 1 5 1", valid64, imm64, ready64);
    else pass_cnt++;
    instr = 32'h00600093;
    step();
    total_cnt++;
    if (ready64 !== 1'b0 || imm64 !== 64'h5)
      $display("FAIL skid_full: rdy=%b imm=%h, expected 0 5", ready64, imm64);
    else pass_cnt++;
    instr = 32'h00700093;
    step();
    total_cnt++;
    if (ready64 !== 1'b0 || valid64 !== 1'b1 || imm64 !== 64'h5 || fmt64 !== 3'd1)
      $display("FAIL skid_hold: rdy=%b v=%b imm=%h fmt=%0d, expected 0 1 5 1",
               ready64, valid64, imm64, fmt64);
    else pass_cnt++;
    rdy = 1'b1;
    step();
    total_cnt++;
    if (valid64 !== 1'b1 || imm64 !== 64'h6 || ready64 !== 1'b1)
      $display("FAIL skid_second: v=%b imm=%h rdy=%b, expected 1 6 1", valid64, imm64, ready64);
    else pass_cnt++;
    step();
    valid = 1'b0;
    total_cnt++;
    if (valid64 !== 1'b1 || imm64 !== 64'h7)
      $display("FAIL skid_third: v=%b imm=%h, expected 1 7", valid64, imm64);
    else pass_cnt++;
    step();
    total_cnt++;
    if (valid64 !== 1'b0)
      $display("FAIL skid_no_dup: o_valid=%b, expected 0", valid64);
    else pass_cnt++;
  endtask

  task automatic test_err_cnt();
    valid = 1'b0; rdy = 1'b1; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    total_cnt++;
    if (cnt64 !== 8'd0 || cnt_e2 !== 2'd0)
      $display("FAIL err_clear_idle: cnt=%0d cnt2=%0d, expected 0 0", cnt64, cnt_e2);
    else pass_cnt++;
    instr = 32'h0000007F;
    for (int k = 1; k <= 5; k++) begin
      valid = 1'b1;
      step();
      total_cnt++;
      if (cnt64 !== 8'(k) || cnt_e2 !== 2'((k > 3) ? 3 : k) || illegal_e2 !== 1'b1 ||
          valid_e2 !== 1'b1 || fmt_e2 !== 3'd0 || imm_e2 !== 64'h0)
        $display("FAIL err_sat[%0d]: cnt=%0d cnt2=%0d ill=%b v=%b fmt=%0d imm=%h, expected %0d %0d 1 1 0 0",
                 k, cnt64, cnt_e2, illegal_e2, valid_e2, fmt_e2, imm_e2, k, (k > 3) ? 3 : k);
      else pass_cnt++;
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0; valid = 1'b0;
    total_cnt++;
    if (cnt64 !== 8'd0 || cnt_e2 !== 2'd0 || illegal64 !== 1'b1)
      $display("FAIL err_clr_prio: cnt=%0d cnt2=%0d ill=%b, expected 0 0 1", cnt64, cnt_e2, illegal64);
    else pass_cnt++;
    rdy = 1'b0; valid = 1'b1;
    step();
    valid = 1'b0;
    total_cnt++;
    if (cnt64 !== 8'd1 || valid64 !== 1'b1)
      $display("FAIL err_at_accept: cnt=%0d v=%b, expected 1 1", cnt64, valid64);
    else pass_cnt++;
    rdy = 1'b1;
    step(); step();
    total_cnt++;
    if (cnt64 !== 8'd1 || valid64 !== 1'b0)
      $display("FAIL err_not_at_output: cnt=%0d v=%b, expected 1 0", cnt64, valid64);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    rdy = 1'b0; valid = 1'b1; instr = 32'h0000007F;
    step();
    instr = 32'h00100093;
    step();
    valid = 1'b0;
    total_cnt++;
    if (ready64 !== 1'b0 || cnt64 !== 8'd2)
      $display("FAIL rstmid_setup: rdy=%b cnt=%0d, expected 0 2", ready64, cnt64);
    else pass_cnt++;
    rst_n = 1'b0;
    step();
    total_cnt++;
    if (valid64 !== 1'b0 || cnt64 !== 8'd0 || ready64 !== 1'b0)
      $display("FAIL rstmid_flush: v=%b cnt=%0d rdy=%b, expected 0 0 0", valid64, cnt64, ready64);
    else pass_cnt++;
    rst_n = 1'b1; rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total_cnt++;
      if (valid64 !== 1'b0 || ready64 !== 1'b1)
        $display("FAIL rstmid_stale[%0d]: v=%b rdy=%b, expected 0 1", k, valid64, ready64);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_formats();
    test_back_to_back();
    test_skid();
    test_err_cnt();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL provide parameter XLEN, default 64: width of the extended immediate, legal values 32 and 64.
REQ-002 SHALL provide parameter ERR_CNT_W, default 8: width of the illegal-opcode counter.
REQ-003 SHALL provide i_clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL provide i_rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL provide i_valid  input  1: upstream instruction valid.
REQ-006 SHALL provide o_ready  output  1: block accepts an instruction this cycle.
REQ-007 SHALL provide i_instr  input  32: RV instruction word.
REQ-008 SHALL provide o_valid  output  1: result valid.
REQ-009 SHALL provide i_ready  input  1: downstream accepts result.
REQ-010 SHALL provide o_imm  output  XLEN: sign-extended immediate.
REQ-011 SHALL provide o_fmt  output  3: format code, 0=NONE 1=I 2=S 3=B 4=U 5=J.
REQ-012 SHALL provide o_illegal  output  1: opcode not in the supported set.
REQ-013 SHALL provide o_err_cnt  output  ERR_CNT_W: saturating count of accepted illegal opcodes.
REQ-014 SHALL provide i_err_clr  input  1: synchronous clear of o_err_cnt.

Function
REQ-015 SHALL decode opcode i_instr[6:0]: I for 0010011, 0000011, 1100111; S for 0100011; B for 1100011; U for 0110111, 0010111; J for 1101111; any other opcode gives NONE.
REQ-016 SHALL form I imm as sext(instr[31:20]).
REQ-017 SHALL form S imm as sext({instr[31:25], instr[11:7]}).
REQ-018 SHALL form B imm as sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
REQ-019 SHALL form U imm as sext({instr[31:12], 12'b0}); upper bits replicate instr[31] when XLEN=64.
REQ-020 SHALL form J imm as sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
REQ-021 SHALL drive o_imm=0, o_fmt=0, o_illegal=1 for NONE.
REQ-022 SHALL accept on i_valid && o_ready, with a transfer on the output side on o_valid && i_ready.
REQ-023 SHALL use a two-entry skid buffer: main output register plus one skid register; o_ready = skid register empty.
REQ-024 SHALL have latency exactly one cycle from accept to o_valid when the skid register is empty.
REQ-025 SHALL hold o_imm, o_fmt and o_illegal stable while o_valid && !i_ready.
REQ-026 SHALL load an accept into the skid register when the output register is full and not draining; the skid entry moves to the output register on the next drain, preserving order.
REQ-027 SHALL, on simultaneous accept and drain with the skid register empty, load the new result into the output register with no bubble; full throughput is one instruction per cycle.
REQ-028 SHALL increment o_err_cnt once per accepted illegal instruction, at acceptance and not at output, and saturate at all-ones.
REQ-029 SHALL give i_err_clr priority over a same-cycle increment, resulting in 0.
REQ-030 SHALL keep o_illegal meaningful only while o_valid=1.

Reset
REQ-031 SHALL, while i_rst_n=0 at a clock edge: o_valid=0, skid register empty, o_imm=0, o_fmt=0, o_illegal=0, o_err_cnt=0.
REQ-032 SHALL drive o_ready=0 during reset and 1 on the first cycle after deassertion.
REQ-033 SHALL, when reset is asserted mid-operation, discard both buffered entries without emitting them.

Verification
REQ-034 SHALL be verified with: XLEN=64, instr 0xFFF00093 (addi -1) with i_ready=1 -> next cycle o_valid=1, o_fmt=1, o_imm=0xFFFFFFFFFFFFFFFF.
REQ-035 SHALL be verified with: branch 0xFE000EE3 -> o_fmt=3, o_imm=-4 (0xFFFFFFFFFFFFFFFC); jal 0x0080006F -> o_fmt=5, o_imm=8.
REQ-036 SHALL be verified with: lui 0x800002B7, XLEN=32 -> o_imm=0x80000000; XLEN=64 -> 0xFFFFFFFF80000000.
REQ-037 SHALL be verified with: i_ready=0, three back-to-back valid instructions -> first two accepted, o_ready=0 on the third; after i_ready=1, outputs appear in order with none lost or duplicated.
REQ-038 SHALL be verified with: ERR_CNT_W=2, five illegal opcodes 0x0000007F -> o_err_cnt=3 (saturated), o_illegal=1 per result; i_err_clr together with an illegal accept -> 0.
REQ-039 SHALL be verified with: i_rst_n=0 while both entries are full -> o_valid=0, o_err_cnt=0 next cycle, and no stale output after release.
